multisim_axi_txn_limiter: RTL and testbench

Sits directly upstream of the multisim AXI push server, between the DUT's AXI manager port and the server's subordinate port. Passes all five AXI channels through with zero latency. Caps outstanding write and read transactions so the channel queues behind the server cannot be flooded. Supports a drain/quiesce handshake so testbench software can stop new traffic before a checkpoint or shutdown.

---
 rtl/multisim_axi_pkg.sv | 20 ++
 rtl/multisim_txn_counter.sv | 61 ++++++
 rtl/multisim_axi_txn_limiter.sv | 179 +++++++++++++++++
 tb/tb_multisim_axi_txn_limiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multisim_axi_pkg.sv
// Shared types and helpers for the multisim AXI transaction limiter.
package multisim_axi_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_IDLE  = 2'd2
    } lim_state_e;

    // Default R payload; any replacement type must also carry a 1-bit 'last'.
    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } axi_r_dflt_t;

    function automatic int cnt_width(input int max_txn);
        return (max_txn < 32'sd1) ? 32'sd1 : $clog2(max_txn + 32'sd1);
    endfunction

endpackage

// File: rtl/multisim_txn_counter.sv
// Outstanding-transaction counter with a limit flag and a sticky error on underflow/overflow.
module multisim_txn_counter
    import multisim_axi_pkg::*;
#(
    parameter int MAX = 8,
    localparam int W  = cnt_width(MAX)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_at_max,
    output logic         o_err
);

    localparam logic [W-1:0] MAX_C = W'(MAX);
    localparam logic [W-1:0] ONE_C = W'(1'b1);

    logic [W-1:0] r_count;
    logic [W-1:0] w_count_nxt;
    logic         r_err;
    logic         w_err_nxt;

    // Next count; simultaneous inc/dec cancel, illegal moves hold the count and flag
    always_comb begin
        w_count_nxt = r_count;
        w_err_nxt   = r_err;
        if (i_inc && !i_dec) begin
            if (r_count >= MAX_C) begin
                w_err_nxt = 1'b1;
            end else begin
                w_count_nxt = r_count + ONE_C;
            end
        end else if (i_dec && !i_inc) begin
            if (r_count == '0) begin
                w_err_nxt = 1'b1;
            end else begin
                w_count_nxt = r_count - ONE_C;
            end
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Count and sticky error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign o_count  = r_count;
    assign o_at_max = (r_count >= MAX_C);
    assign o_err    = r_err;

endmodule

// File: rtl/multisim_axi_txn_limiter.sv
// Zero-latency AXI pass-through that caps outstanding writes/reads and supports drain/quiesce.
// Optional statistics counters with an end-of-sim report: define MULTISIM_AXI_LIMITER_STATS_EN.
module multisim_axi_txn_limiter
    import multisim_axi_pkg::*;
#(
    parameter type axi_aw_t = logic [31:0],
    parameter type axi_w_t  = logic [31:0],
    parameter type axi_b_t  = logic [1:0],
    parameter type axi_ar_t = logic [31:0],
    parameter type axi_r_t  = axi_r_dflt_t,
    parameter int  MAX_WR_TXN = 8,
    parameter int  MAX_RD_TXN = 8
) (
    input  logic    clk,
    input  logic    rst_n,
    input  axi_aw_t i_axi_s_aw,
    input  logic    i_axi_s_awvalid,
    output logic    o_axi_s_awready,
    input  axi_w_t  i_axi_s_w,
    input  logic    i_axi_s_wvalid,
    output logic    o_axi_s_wready,
    output axi_b_t  o_axi_s_b,
    output logic    o_axi_s_bvalid,
    input  logic    i_axi_s_bready,
    input  axi_ar_t i_axi_s_ar,
    input  logic    i_axi_s_arvalid,
    output logic    o_axi_s_arready,
    output axi_r_t  o_axi_s_r,
    output logic    o_axi_s_rvalid,
    input  logic    i_axi_s_rready,
    output axi_aw_t o_axi_m_aw,
    output logic    o_axi_m_awvalid,
    input  logic    i_axi_m_awready,
    output axi_w_t  o_axi_m_w,
    output logic    o_axi_m_wvalid,
    input  logic    i_axi_m_wready,
    input  axi_b_t  i_axi_m_b,
    input  logic    i_axi_m_bvalid,
    output logic    o_axi_m_bready,
    output axi_ar_t o_axi_m_ar,
    output logic    o_axi_m_arvalid,
    input  logic    i_axi_m_arready,
    input  axi_r_t  i_axi_m_r,
    input  logic    i_axi_m_rvalid,
    output logic    o_axi_m_rready,
    input  logic    i_drain_req,
    output logic    o_idle,
    output logic [cnt_width(MAX_WR_TXN)-1:0] o_wr_outstanding,
    output logic [cnt_width(MAX_RD_TXN)-1:0] o_rd_outstanding,
    output logic    o_err
);

    localparam int WW = cnt_width(MAX_WR_TXN);
    localparam int RW = cnt_width(MAX_RD_TXN);

    lim_state_e    r_state;
    lim_state_e    w_state_nxt;
    logic          r_idle;
    logic          w_wr_at_max, w_rd_at_max, w_wr_err, w_rd_err;
    logic [WW-1:0] w_wr_cnt;
    logic [RW-1:0] w_rd_cnt;
    logic          w_aw_open, w_ar_open;
    logic          w_aw_hs, w_ar_hs, w_b_hs, w_r_last_hs;

    assign w_aw_open   = (r_state == ST_RUN) && !w_wr_at_max;
    assign w_ar_open   = (r_state == ST_RUN) && !w_rd_at_max;
    assign w_aw_hs     = i_axi_s_awvalid & i_axi_m_awready & w_aw_open;
    assign w_ar_hs     = i_axi_s_arvalid & i_axi_m_arready & w_ar_open;
    assign w_b_hs      = i_axi_m_bvalid & i_axi_s_bready;
    assign w_r_last_hs = i_axi_m_rvalid & i_axi_s_rready & i_axi_m_r.last;

    assign o_axi_m_aw      = i_axi_s_aw;
    assign o_axi_m_awvalid = i_axi_s_awvalid & w_aw_open;
    assign o_axi_s_awready = i_axi_m_awready & w_aw_open;
    assign o_axi_m_ar      = i_axi_s_ar;
    assign o_axi_m_arvalid = i_axi_s_arvalid & w_ar_open;
    assign o_axi_s_arready = i_axi_m_arready & w_ar_open;
    assign o_axi_m_w       = i_axi_s_w;
    assign o_axi_m_wvalid  = i_axi_s_wvalid;
    assign o_axi_s_wready  = i_axi_m_wready;
    assign o_axi_s_b       = i_axi_m_b;
    assign o_axi_s_bvalid  = i_axi_m_bvalid;
    assign o_axi_m_bready  = i_axi_s_bready;
    assign o_axi_s_r       = i_axi_m_r;
    assign o_axi_s_rvalid  = i_axi_m_rvalid;
    assign o_axi_m_rready  = i_axi_s_rready;

    multisim_txn_counter #(.MAX(MAX_WR_TXN)) u_wr_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_inc    (w_aw_hs),
        .i_dec    (w_b_hs),
        .o_count  (w_wr_cnt),
        .o_at_max (w_wr_at_max),
        .o_err    (w_wr_err)
    );

    multisim_txn_counter #(.MAX(MAX_RD_TXN)) u_rd_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_inc    (w_ar_hs),
        .i_dec    (w_r_last_hs),
        .o_count  (w_rd_cnt),
        .o_at_max (w_rd_at_max),
        .o_err    (w_rd_err)
    );

    // Quiesce FSM; idle is judged on registered counts, so IDLE lags the last completion by a cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (i_drain_req) w_state_nxt = ST_DRAIN;
                else             w_state_nxt = ST_RUN;
            end
            ST_DRAIN: begin
                if (!i_drain_req)                              w_state_nxt = ST_RUN;
                else if ((w_wr_cnt == '0) && (w_rd_cnt == '0)) w_state_nxt = ST_IDLE;
                else                                           w_state_nxt = ST_DRAIN;
            end
            ST_IDLE: begin
                if (!i_drain_req) w_state_nxt = ST_RUN;
                else              w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // State register and registered idle flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_idle  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idle  <= (w_state_nxt == ST_IDLE);
        end
    end

    assign o_idle           = r_idle;
    assign o_wr_outstanding = w_wr_cnt;
    assign o_rd_outstanding = w_rd_cnt;
    assign o_err            = w_wr_err | w_rd_err;

`ifdef MULTISIM_AXI_LIMITER_STATS_EN
    logic [31:0]   r_st_aw_total, r_st_ar_total, r_st_aw_stall, r_st_ar_stall;
    logic [WW-1:0] r_st_wr_peak;
    logic [RW-1:0] r_st_rd_peak;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Traffic statistics; a stall counts only when the limit itself blocks a presented request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st_aw_total <= 32'd0;
            r_st_ar_total <= 32'd0;
            r_st_aw_stall <= 32'd0;
            r_st_ar_stall <= 32'd0;
            r_st_wr_peak  <= '0;
            r_st_rd_peak  <= '0;
        end else begin
            if (w_aw_hs) r_st_aw_total <= sat_inc(r_st_aw_total);
            if (w_ar_hs) r_st_ar_total <= sat_inc(r_st_ar_total);
            if (i_axi_s_awvalid && (r_state == ST_RUN) && w_wr_at_max) r_st_aw_stall <= sat_inc(r_st_aw_stall);
            if (i_axi_s_arvalid && (r_state == ST_RUN) && w_rd_at_max) r_st_ar_stall <= sat_inc(r_st_ar_stall);
            if (w_wr_cnt > r_st_wr_peak) r_st_wr_peak <= w_wr_cnt;
            if (w_rd_cnt > r_st_rd_peak) r_st_rd_peak <= w_rd_cnt;
        end
    end

    final begin
        $display("%m: aw_total=%0d ar_total=%0d aw_stall=%0d ar_stall=%0d wr_peak=%0d rd_peak=%0d",
                 r_st_aw_total, r_st_ar_total, r_st_aw_stall, r_st_ar_stall, r_st_wr_peak, r_st_rd_peak);
    end
`endif

endmodule

// File: tb/tb_multisim_axi_txn_limiter.sv
// Directed bench for the AXI transaction limiter with a reference model checked every cycle.
module tb_multisim_axi_txn_limiter;

    localparam int MAX_WR = 3;
    localparam int MAX_RD = 1;
    localparam int WW = $clog2(MAX_WR + 1);
    localparam int RW = $clog2(MAX_RD + 1);
    localparam int MD_RUN = 0, MD_DRAIN = 1, MD_IDLE = 2;

    typedef logic [15:0] aw_t;
    typedef logic [15:0] w_t;
    typedef logic [3:0]  b_t;
    typedef logic [15:0] ar_t;
    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } r_t;

    logic clk = 1'b0;
    logic rst_n;
    aw_t  s_aw, m_aw;
    logic s_awvalid, s_awready, m_awvalid, m_awready;
    w_t   s_w, m_w;
    logic s_wvalid, s_wready, m_wvalid, m_wready;
    b_t   s_b, m_b;
    logic s_bvalid, s_bready, m_bvalid, m_bready;
    ar_t  s_ar, m_ar;
    logic s_arvalid, s_arready, m_arvalid, m_arready;
    r_t   s_r, m_r;
    logic s_rvalid, s_rready, m_rvalid, m_rready;
    logic drain, idle, err;
    logic [WW-1:0] wr_o;
    logic [RW-1:0] rd_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multisim_axi_txn_limiter #(
        .axi_aw_t(aw_t), .axi_w_t(w_t), .axi_b_t(b_t), .axi_ar_t(ar_t), .axi_r_t(r_t),
        .MAX_WR_TXN(MAX_WR), .MAX_RD_TXN(MAX_RD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_axi_s_aw(s_aw), .i_axi_s_awvalid(s_awvalid), .o_axi_s_awready(s_awready),
        .i_axi_s_w(s_w), .i_axi_s_wvalid(s_wvalid), .o_axi_s_wready(s_wready),
        .o_axi_s_b(s_b), .o_axi_s_bvalid(s_bvalid), .i_axi_s_bready(s_bready),
        .i_axi_s_ar(s_ar), .i_axi_s_arvalid(s_arvalid), .o_axi_s_arready(s_arready),
        .o_axi_s_r(s_r), .o_axi_s_rvalid(s_rvalid), .i_axi_s_rready(s_rready),
        .o_axi_m_aw(m_aw), .o_axi_m_awvalid(m_awvalid), .i_axi_m_awready(m_awready),
        .o_axi_m_w(m_w), .o_axi_m_wvalid(m_wvalid), .i_axi_m_wready(m_wready),
        .i_axi_m_b(m_b), .i_axi_m_bvalid(m_bvalid), .o_axi_m_bready(m_bready),
        .o_axi_m_ar(m_ar), .o_axi_m_arvalid(m_arvalid), .i_axi_m_arready(m_arready),
        .i_axi_m_r(m_r), .i_axi_m_rvalid(m_rvalid), .o_axi_m_rready(m_rready),
        .i_drain_req(drain), .o_idle(idle),
        .o_wr_outstanding(wr_o), .o_rd_outstanding(rd_o), .o_err(err)
    );

    // Reference model: outstanding counts, operating mode and sticky error
    int mdl_wcnt, mdl_rcnt, mdl_mode;
    bit mdl_err;
    wire mdl_aw_open = (mdl_mode == MD_RUN) && (mdl_wcnt < MAX_WR);
    wire mdl_ar_open = (mdl_mode == MD_RUN) && (mdl_rcnt < MAX_RD);
    wire mdl_aw_hs   = s_awvalid && m_awready && mdl_aw_open;
    wire mdl_ar_hs   = s_arvalid && m_arready && mdl_ar_open;
    wire mdl_b_hs    = m_bvalid && s_bready;
    wire mdl_rl_hs   = m_rvalid && s_rready && m_r.last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_wcnt <= 0;
            mdl_rcnt <= 0;
            mdl_mode <= MD_RUN;
            mdl_err  <= 1'b0;
        end else begin
            if (mdl_aw_hs && !mdl_b_hs) mdl_wcnt <= mdl_wcnt + 1;
            else if (mdl_b_hs && !mdl_aw_hs) begin
                if (mdl_wcnt == 0) mdl_err <= 1'b1;
                else               mdl_wcnt <= mdl_wcnt - 1;
            end
            if (mdl_ar_hs && !mdl_rl_hs) mdl_rcnt <= mdl_rcnt + 1;
            else if (mdl_rl_hs && !mdl_ar_hs) begin
                if (mdl_rcnt == 0) mdl_err <= 1'b1;
                else               mdl_rcnt <= mdl_rcnt - 1;
            end
            case (mdl_mode)
                MD_RUN:   mdl_mode <= drain ? MD_DRAIN : MD_RUN;
                MD_DRAIN: mdl_mode <= !drain ? MD_RUN :
                                      ((mdl_wcnt == 0 && mdl_rcnt == 0) ? MD_IDLE : MD_DRAIN);
                default:  mdl_mode <= drain ? MD_IDLE : MD_RUN;
            endcase
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("m_awvalid", m_awvalid, s_awvalid && mdl_aw_open);
        chk("s_awready", s_awready, m_awready && mdl_aw_open);
        chk("m_arvalid", m_arvalid, s_arvalid && mdl_ar_open);
        chk("s_arready", s_arready, m_arready && mdl_ar_open);
        chk("wr_cnt", wr_o, mdl_wcnt);
        chk("rd_cnt", rd_o, mdl_rcnt);
        chk("idle", idle, mdl_mode == MD_IDLE);
        chk("err", err, mdl_err);
        chk("aw_pass", m_aw, s_aw);
        chk("ar_pass", m_ar, s_ar);
        chk("w_pass", {m_wvalid, s_wready, m_w}, {s_wvalid, m_wready, s_w});
        chk("b_pass", {s_bvalid, m_bready, s_b}, {m_bvalid, s_bready, m_b});
        chk("r_pass", {s_rvalid, m_rready, s_r}, {m_rvalid, s_rready, m_r});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; drain = 1'b0;
        s_aw = 16'h1000; s_awvalid = 1'b0; m_awready = 1'b1;
        s_w = 16'h5a5a; s_wvalid = 1'b0; m_wready = 1'b1;
        m_b = 4'h0; m_bvalid = 1'b0; s_bready = 1'b0;
        s_ar = 16'h2000; s_arvalid = 1'b0; m_arready = 1'b1;
        m_r = '{data: 8'h00, last: 1'b0}; m_rvalid = 1'b0; s_rready = 1'b0;
        tick(2);
        chk("rst_wr", wr_o, 0); chk("rst_err", err, 0); chk("rst_idle", idle, 0);
        rst_n = 1'b1;
        tick(1);

        // Write limit: three accepted, fourth held until a B returns
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin s_aw = 16'h1000 + 16'(i); tick(1); end
        s_aw = 16'h1003;
        chk("lim_wr3", wr_o, 3); chk("lim_awready0", s_awready, 0); chk("lim_awvalid0", m_awvalid, 0);
        tick(1);
        m_bvalid = 1'b1; s_bready = 1'b1; m_b = 4'h1;
        tick(1);
        m_bvalid = 1'b0;
        chk("b_wr2", wr_o, 2); chk("b_reopen", s_awready, 1);
        tick(1);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        chk("aw4_wr3", wr_o, 3);
        m_bvalid = 1'b1; m_b = 4'h2;
        tick(3);
        m_bvalid = 1'b0;
        chk("wr_empty", wr_o, 0);

        // Same-cycle AW and B at count 1
        s_awvalid = 1'b1; s_aw = 16'h1100;
        tick(1);
        m_bvalid = 1'b1;
        tick(1);
        chk("same_wr1", wr_o, 1); chk("same_err0", err, 0);
        s_awvalid = 1'b0;
        tick(1);
        m_bvalid = 1'b0;

        // Read limit of one with a 4-beat burst
        s_arvalid = 1'b1; s_rready = 1'b1;
        tick(1);
        s_ar = 16'h2001;
        chk("ar_rd1", rd_o, 1); chk("ar_blocked", s_arready, 0);
        m_rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin m_r = '{data: 8'(i + 1), last: 1'b0}; tick(1); end
        chk("beat3_rd1", rd_o, 1);
        m_r = '{data: 8'h04, last: 1'b1};
        tick(1);
        m_rvalid = 1'b0;
        chk("last_rd0", rd_o, 0); chk("ar2_ready", s_arready, 1);
        tick(1);
        s_arvalid = 1'b0;
        chk("ar2_rd1", rd_o, 1);
        m_rvalid = 1'b1;
        tick(1);
        m_rvalid = 1'b0;

        // Drain with two writes and one read outstanding
        s_awvalid = 1'b1; s_aw = 16'h1200;
        tick(2);
        s_awvalid = 1'b0; s_arvalid = 1'b1; s_ar = 16'h2100;
        tick(1);
        s_arvalid = 1'b0; drain = 1'b1;
        tick(1);
        s_awvalid = 1'b1; s_arvalid = 1'b1;
        chk("drn_awblk", m_awvalid, 0); chk("drn_arblk", m_arvalid, 0); chk("drn_idle0", idle, 0);
        m_bvalid = 1'b1;
        tick(2);
        m_bvalid = 1'b0; m_rvalid = 1'b1;
        tick(1);
        m_rvalid = 1'b0;
        chk("drn_cnt0_idle0", idle, 0);
        tick(1);
        chk("drn_idle1", idle, 1); chk("idle_awblk", m_awvalid, 0);
        drain = 1'b0;
        tick(1);
        chk("resume_idle0", idle, 0); chk("resume_aw", m_awvalid, 1); chk("resume_ar", m_arvalid, 1);
        tick(1);
        s_awvalid = 1'b0; s_arvalid = 1'b0;
        chk("resume_wr1", wr_o, 1); chk("resume_rd1", rd_o, 1);
        m_bvalid = 1'b1; m_rvalid = 1'b1;
        tick(1);
        m_bvalid = 1'b0; m_rvalid = 1'b0;

        // Spurious B at zero count sets the sticky error
        m_bvalid = 1'b1;
        tick(1);
        m_bvalid = 1'b0;
        chk("spur_wr0", wr_o, 0); chk("spur_err1", err, 1);
        tick(3);
        chk("spur_sticky", err, 1);

        // Asynchronous reset mid-burst at count 3
        s_awvalid = 1'b1; s_aw = 16'h1300;
        tick(3);
        s_awvalid = 1'b0;
        chk("pre_rst_wr3", wr_o, 3);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_wr0", wr_o, 0); chk("arst_rd0", rd_o, 0);
        chk("arst_err0", err, 0); chk("arst_idle0", idle, 0);
        tick(1);
        rst_n = 1'b1;
        m_bvalid = 1'b1;
        tick(1);
        m_bvalid = 1'b0;
        chk("lost_b_err", err, 1);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
